// File: rtl/cpu_trace_buffer_if.sv
// Trace-buffer bus: CPU trace taps and console control/readback in one bundle.
// The CPU/console side uses the master modport; the buffer uses the slave modport.
interface cpu_trace_buffer_if #(
    parameter int DEPTH = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic [18:35] cpuPC;
    logic [0:35]  cpuHR;
    logic         regsLOAD;
    logic         trARM;
    logic         trCLR;
    logic         trMATCHEN;
    logic [18:35] trMATCH;
    logic         trSTOPFULL;
    logic         rdREQ;

    logic [0:63]  trDATA;
    logic         trVALID;
    logic [0:AW]  trCOUNT;
    logic         trFULL;
    logic         trOVFL;
    logic [0:1]   trSTATE;
    logic         trHALT;

    modport master (
        output cpuPC, cpuHR, regsLOAD, trARM, trCLR, trMATCHEN, trMATCH,
               trSTOPFULL, rdREQ,
        input  trDATA, trVALID, trCOUNT, trFULL, trOVFL, trSTATE, trHALT
    );

    modport slave (
        input  cpuPC, cpuHR, regsLOAD, trARM, trCLR, trMATCHEN, trMATCH,
               trSTOPFULL, rdREQ,
        output trDATA, trVALID, trCOUNT, trFULL, trOVFL, trSTATE, trHALT
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// KS10 instruction-trace capture: (PC, HR) pairs into a FIFO behind an optional
// PC-match trigger, with stop-and-halt or wrap-and-overwrite policy on full.
module cpu_trace_buffer #(
    parameter int DEPTH = 1024
) (
    input logic             clk,
    input logic             rst,
    cpu_trace_buffer_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DATA_W = 54;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                ovfl;
    logic                halt_p1;
    logic [63:0]         rd_data_p1;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic clear, wr_en, pop, overwrite, halt_d;
    logic full, trig_hit;

    assign full     = (count == FULL_CNT);
    assign trig_hit = !bus.trMATCHEN || (bus.cpuPC == bus.trMATCH);

    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        wr_en     = 1'b0;
        pop       = 1'b0;
        overwrite = 1'b0;
        halt_d    = 1'b0;
        if (bus.trCLR) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else if (bus.trARM && (state_q == IDLE || state_q == DONE)) begin
            state_d = ARMED;
            clear   = 1'b1;
        end else begin
            pop = bus.rdREQ && (count != '0);
            unique case (state_q)
                ARMED: begin
                    if (bus.regsLOAD && trig_hit) begin
                        wr_en   = 1'b1;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.regsLOAD) begin
                        // Stop policy switched on while already full: drop and stop.
                        if (full && bus.trSTOPFULL && !pop) begin
                            state_d = DONE;
                        end else begin
                            wr_en     = 1'b1;
                            overwrite = full && !pop;
                            if (bus.trSTOPFULL && !pop && count == LAST_CNT) begin
                                state_d = DONE;
                                halt_d  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: control state, pointers and the popped entry register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovfl       <= 1'b0;
            halt_p1    <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            state_q <= state_d;
            halt_p1 <= halt_d;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovfl   <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                // An overwrite retires the oldest entry exactly like a pop does.
                if (pop || overwrite)
                    rd_ptr <= rd_ptr + 1'b1;
                if (wr_en && !pop && !full)
                    count <= count + 1'b1;
                else if (pop && !wr_en)
                    count <= count - 1'b1;
                if (overwrite)
                    ovfl <= 1'b1;
            end
            if (pop)
                rd_data_p1 <= {10'd0, mem[rd_ptr]};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {bus.cpuPC, bus.cpuHR};
    end

    assign bus.trDATA  = rd_data_p1;
    assign bus.trVALID = (count != '0);
    assign bus.trCOUNT = count;
    assign bus.trFULL  = full;
    assign bus.trOVFL  = ovfl;
    assign bus.trSTATE = state_q;
    assign bus.trHALT  = halt_p1;
endmodule
